// File: rtl/weight_bank_pingpong.sv
// Double-buffered weight bank: a shadow buffer is streamed in while the active buffer is read.
// Optional per-word even parity is enabled by defining WEIGHT_PARITY_EN (adds the rd_perr output).
module weight_bank_pingpong #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2048,
    parameter int LAYER_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csen,
    input  logic                  load_start,
    input  logic [LAYER_W-1:0]    load_layer,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  load_done,
    input  logic                  swap,
    output logic                  swap_err,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_oob,
`ifdef WEIGHT_PARITY_EN
    output logic                  rd_perr,
`endif
    output logic [LAYER_W-1:0]    active_layer,
    output logic                  active_ready,
    output logic                  busy
);

`ifdef WEIGHT_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + 1;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif
    localparam int IDX_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_active_sel;
    logic                  r_active_valid;
    logic [LAYER_W-1:0]    r_active_layer;
    logic [ADDR_WIDTH:0]   r_active_len;
    logic                  r_shadow_valid;
    logic [LAYER_W-1:0]    r_shadow_layer;
    logic [ADDR_WIDTH:0]   r_shadow_len;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic                  r_load_done;
    logic                  r_swap_err;
    logic                  r_rd_valid;
    logic                  r_rd_oob;
    logic [MEM_W-1:0]      r_rd_q;
    logic [MEM_W-1:0]      r_mem [0:2*DEPTH-1];

    logic                  w_start;
    logic                  w_len_zero;
    logic                  w_swap_req;
    logic                  w_swap_ok;
    logic                  w_beat;
    logic                  w_last;
    logic                  w_complete;
    logic                  w_rd_req;
    logic                  w_rd_ok;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [MEM_W-1:0]      w_wr_word;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a load_start restarts the load from any state
    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = w_len_zero ? S_FULL : S_LOAD;
        end else begin
            case (r_state)
                S_LOAD:  if (w_last)    w_state_next = S_FULL;
                S_FULL:  if (w_swap_ok) w_state_next = S_IDLE;
                default: w_state_next = r_state;
            endcase
        end
    end

    // Output / command decode
    always_comb begin
        w_start    = load_start & csen;
        w_len_zero = (load_len == '0);
        w_swap_req = swap & csen;
        w_swap_ok  = w_swap_req & (r_state == S_FULL);
        wr_ready   = csen & (r_state == S_LOAD);
        busy       = (r_state == S_LOAD);
        w_beat     = wr_valid & wr_ready;
        w_last     = w_beat & ({1'b0, r_wr_ptr} == (r_shadow_len - (ADDR_WIDTH+1)'(1)));
        w_complete = w_start ? w_len_zero : w_last;
    end

    always_comb begin
        w_rd_req = rd_en & csen;
        w_rd_ok  = w_rd_req & r_active_valid & ({1'b0, rd_addr} < r_active_len);
        w_rd_idx = r_active_sel ? (IDX_W'(DEPTH) + {1'b0, rd_addr}) : {1'b0, rd_addr};
        w_wr_idx = r_active_sel ? {1'b0, r_wr_ptr} : (IDX_W'(DEPTH) + {1'b0, r_wr_ptr});
`ifdef WEIGHT_PARITY_EN
        w_wr_word = {^wr_data, wr_data};
`else
        w_wr_word = wr_data;
`endif
    end

    // Buffer bookkeeping; a start in the swap cycle overrides the shadow fields handed back by the swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_sel   <= 1'b0;
            r_active_valid <= 1'b0;
            r_active_layer <= '0;
            r_active_len   <= '0;
            r_shadow_valid <= 1'b0;
            r_shadow_layer <= '0;
            r_shadow_len   <= '0;
            r_wr_ptr       <= '0;
            r_load_done    <= 1'b0;
            r_swap_err     <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_rd_oob       <= 1'b0;
        end else begin
            r_load_done <= w_complete;
            r_swap_err  <= w_swap_req & (r_state != S_FULL);
            r_rd_valid  <= w_rd_ok;
            r_rd_oob    <= w_rd_req & ~w_rd_ok;
            if (w_swap_ok) begin
                r_active_sel   <= ~r_active_sel;
                r_active_valid <= r_shadow_valid;
                r_active_layer <= r_shadow_layer;
                r_active_len   <= r_shadow_len;
                r_shadow_valid <= 1'b0;
                r_shadow_layer <= r_active_layer;
                r_shadow_len   <= r_active_len;
            end
            if (w_start) begin
                r_shadow_layer <= load_layer;
                r_shadow_len   <= load_len;
                r_shadow_valid <= w_len_zero;
                r_wr_ptr       <= '0;
            end else if (w_beat) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_last) begin
                    r_shadow_valid <= 1'b1;
                end
            end
        end
    end

    // Both buffers share one array: writes hit the shadow half, reads the active half
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_mem[w_wr_idx] <= w_wr_word;
        end
        if (w_rd_ok) begin
            r_rd_q <= r_mem[w_rd_idx];
        end
    end

    assign rd_data      = r_rd_valid ? r_rd_q[DATA_WIDTH-1:0] : '0;
    assign rd_valid     = r_rd_valid;
    assign rd_oob       = r_rd_oob;
    assign load_done    = r_load_done;
    assign swap_err     = r_swap_err;
    assign active_layer = r_active_layer;
    assign active_ready = r_active_valid;
`ifdef WEIGHT_PARITY_EN
    assign rd_perr      = r_rd_valid & (^r_rd_q);
`endif

endmodule

// File: tb/tb_weight_bank_pingpong.sv
// Scoreboard bench for weight_bank_pingpong: reads push expected responses, a negedge monitor checks them.
module tb_weight_bank_pingpong;

    logic        clk;
    logic        rst_n;
    logic        csen;
    logic        load_start;
    logic [3:0]  load_layer;
    logic [11:0] load_len;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        load_done;
    logic        swap;
    logic        swap_err;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_oob;
`ifdef WEIGHT_PARITY_EN
    logic        rd_perr;
`endif
    logic [3:0]  active_layer;
    logic        active_ready;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    // {perr, valid, oob, data}
    logic [10:0] exp_q [$];

    weight_bank_pingpong dut (
        .clk(clk), .rst_n(rst_n), .csen(csen),
        .load_start(load_start), .load_layer(load_layer), .load_len(load_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .load_done(load_done), .swap(swap), .swap_err(swap_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_oob(rd_oob),
`ifdef WEIGHT_PARITY_EN
        .rd_perr(rd_perr),
`endif
        .active_layer(active_layer), .active_ready(active_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req_read(input logic [10:0] addr, input logic [7:0] d, input logic v, input logic oob);
        rd_en   = 1'b1;
        rd_addr = addr;
        exp_q.push_back({1'b0, v, oob, d});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_data"}, 32'(rd_data), 0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
        chk({tag, "_rd_oob"}, 32'(rd_oob), 0);
        chk({tag, "_load_done"}, 32'(load_done), 0);
        chk({tag, "_swap_err"}, 32'(swap_err), 0);
        chk({tag, "_active_layer"}, 32'(active_layer), 0);
        chk({tag, "_active_ready"}, 32'(active_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 0);
    endtask

    // Full load of len words: data = base + step*i
    task automatic load_buf(input logic [3:0] tag, input int len, input logic [7:0] base, input logic [7:0] step);
        load_start = 1'b1;
        load_layer = tag;
        load_len   = 12'(len);
        cyc();
        load_start = 1'b0;
        chk("load_busy", 32'(busy), 1);
        wr_valid = 1'b1;
        for (int i = 0; i < len; i++) begin
            wr_data = 8'(base + step * 8'(i));
            chk("load_wr_ready", 32'(wr_ready), 1);
            cyc();
        end
        chk("load_done_pulse", 32'(load_done), 1);
        chk("load_ready_after", 32'(wr_ready), 0);
        chk("load_busy_after", 32'(busy), 0);
        wr_valid = 1'b0;
        cyc();
        chk("load_done_single", 32'(load_done), 0);
    endtask

    task automatic do_swap(input logic [3:0] exp_layer);
        swap = 1'b1;
        cyc();
        swap = 1'b0;
        chk("swap_layer", 32'(active_layer), 32'(exp_layer));
        chk("swap_ready", 32'(active_ready), 1);
        chk("swap_no_err", 32'(swap_err), 0);
    endtask

    // Monitor: every presented read response must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && (rd_valid || rd_oob)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rd_unexpected: got data=%0h valid=%0b oob=%0b, required no response",
                         rd_data, rd_valid, rd_oob);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(e[7:0]));
                chk("rd_valid", 32'(rd_valid), 32'(e[9]));
                chk("rd_oob", 32'(rd_oob), 32'(e[8]));
`ifdef WEIGHT_PARITY_EN
                chk("rd_perr", 32'(rd_perr), 32'(e[10]));
`endif
            end
        end
    end

    initial begin
        rst_n = 1'b1; csen = 1'b1; load_start = 1'b0; load_layer = '0; load_len = '0;
        wr_valid = 1'b0; wr_data = '0; swap = 1'b0; rd_en = 1'b0; rd_addr = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        cyc();

        // Load tag 3, four words, swap, read addr 2
        load_buf(4'd3, 4, 8'h11, 8'h11);
        do_swap(4'd3);
        req_read(11'd2, 8'h33, 1'b1, 1'b0);
        cyc();
        rd_en = 1'b0;

        // Out-of-range read and swap in IDLE
        req_read(11'd4, 8'h00, 1'b0, 1'b1);
        cyc();
        rd_en = 1'b0;
        swap = 1'b1;
        cyc();
        swap = 1'b0;
        chk("idle_swap_err", 32'(swap_err), 1);
        chk("idle_swap_layer", 32'(active_layer), 3);
        cyc();
        chk("idle_swap_err_pulse", 32'(swap_err), 0);

        // Buffer A (tag 1) active; stream tag 2 into B while reading A every cycle
        load_buf(4'd1, 4, 8'hA0, 8'h01);
        do_swap(4'd1);
        load_start = 1'b1; load_layer = 4'd2; load_len = 12'd4;
        req_read(11'd0, 8'hA0, 1'b1, 1'b0);
        cyc();
        load_start = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'(8'hB0 + 8'(i));
            req_read(11'((i + 1) % 4), 8'(8'hA0 + 8'((i + 1) % 4)), 1'b1, 1'b0);
            cyc();
        end
        wr_valid = 1'b0;
        rd_en = 1'b0;
        chk("concurrent_load_done", 32'(load_done), 1);
        swap = 1'b1;
        req_read(11'd1, 8'hA1, 1'b1, 1'b0);
        cyc();
        swap = 1'b0;
        chk("concurrent_swap_layer", 32'(active_layer), 2);
        req_read(11'd0, 8'hB0, 1'b1, 1'b0);
        cyc();
        rd_en = 1'b0;

        // load_start together with swap in FULL: new beats land in the old active buffer
        load_buf(4'd5, 4, 8'hC0, 8'h01);
        swap = 1'b1; load_start = 1'b1; load_layer = 4'd6; load_len = 12'd2;
        cyc();
        swap = 1'b0; load_start = 1'b0;
        chk("swapload_layer", 32'(active_layer), 5);
        chk("swapload_busy", 32'(busy), 1);
        chk("swapload_no_err", 32'(swap_err), 0);
        wr_valid = 1'b1;
        wr_data = 8'hD0;
        req_read(11'd0, 8'hC0, 1'b1, 1'b0);
        cyc();
        wr_data = 8'hD1;
        req_read(11'd3, 8'hC3, 1'b1, 1'b0);
        cyc();
        wr_valid = 1'b0;
        rd_en = 1'b0;
        chk("swapload_done", 32'(load_done), 1);
        do_swap(4'd6);
        req_read(11'd0, 8'hD0, 1'b1, 1'b0);
        cyc();
        req_read(11'd1, 8'hD1, 1'b1, 1'b0);
        cyc();
        req_read(11'd2, 8'h00, 1'b0, 1'b1);
        cyc();
        rd_en = 1'b0;

`ifdef WEIGHT_PARITY_EN
        // Corrupt one stored bit of the active word at addr 0 (upper half of the array)
        dut.r_mem[2048] = dut.r_mem[2048] ^ 9'h001;
        rd_en = 1'b1;
        rd_addr = 11'd0;
        exp_q.push_back({1'b1, 1'b1, 1'b0, 8'hD1});
        cyc();
        rd_en = 1'b0;
        cyc();
        dut.r_mem[2048] = dut.r_mem[2048] ^ 9'h001;
`endif

        // Zero-length load: done pulse, no beats accepted
        load_start = 1'b1; load_layer = 4'd7; load_len = 12'd0;
        wr_valid = 1'b1; wr_data = 8'hEE;
        chk("len0_no_ready", 32'(wr_ready), 0);
        cyc();
        load_start = 1'b0;
        chk("len0_done", 32'(load_done), 1);
        chk("len0_ready_after", 32'(wr_ready), 0);
        chk("len0_busy", 32'(busy), 0);
        cyc();
        wr_valid = 1'b0;
        chk("len0_done_single", 32'(load_done), 0);
        do_swap(4'd7);
        req_read(11'd0, 8'h00, 1'b0, 1'b1);
        cyc();
        rd_en = 1'b0;

        // Reset in the middle of a 10-word load
        load_start = 1'b1; load_layer = 4'd9; load_len = 12'd10;
        cyc();
        load_start = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'(8'h50 + 8'(i));
            if (i == 4) begin
                rd_en = 1'b1;
                rd_addr = 11'd0;
            end
            cyc();
        end
        chk("pre_reset_oob", 32'(rd_oob), 1);
        chk("pre_reset_busy", 32'(busy), 1);
        rd_en = 1'b0;
        wr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        chk("post_reset_busy", 32'(busy), 0);
        swap = 1'b1;
        cyc();
        swap = 1'b0;
        chk("post_reset_swap_err", 32'(swap_err), 1);
        chk("post_reset_layer", 32'(active_layer), 0);
        chk("post_reset_ready", 32'(active_ready), 0);
        req_read(11'd0, 8'h00, 1'b0, 1'b1);
        cyc();
        rd_en = 1'b0;

        repeat (3) cyc();
        chk("rd_outstanding", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/weight_bank_pingpong.md
# weight_bank_pingpong

Double-buffered, parametrised weight memory bank for the ECG accelerator PE array. Weights for the next layer are streamed into a shadow buffer while the PE array reads the active buffer. A `swap` command exchanges the two buffers in one cycle. Replaces the per-layer file-loaded bank with a synthesizable valid/ready load port, per-buffer layer tagging, length tracking and out-of-range protection.

## Interface
Parameters:
- `DATA_WIDTH`, 8: weight word width.
- `ADDR_WIDTH`, 11: address width of each buffer.
- `DEPTH`, 2048: words per buffer (≤ 2^ADDR_WIDTH). Total storage is 2×DEPTH.
- `LAYER_W`, 4: layer tag width.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `csen`  in  1  chip select; gates every command, write and read
- `load_start`  in  1  pulse; begin loading shadow buffer
- `load_layer`  in  LAYER_W  layer tag captured with `load_start`
- `load_len`  in  ADDR_WIDTH+1  word count captured with `load_start` (0..DEPTH)
- `wr_valid`  in  1  load data valid
- `wr_data`  in  DATA_WIDTH  load data
- `wr_ready`  out  1  load data accepted when high with `wr_valid`
- `load_done`  out  1  one-cycle pulse; shadow buffer complete
- `swap`  in  1  pulse; exchange active/shadow
- `swap_err`  out  1  one-cycle pulse; `swap` rejected
- `rd_en`  in  1  read request
- `rd_addr`  in  ADDR_WIDTH  read address in active buffer
- `rd_data`  out  DATA_WIDTH  read data
- `rd_valid`  out  1  `rd_data` valid
- `rd_oob`  out  1  read address ≥ active length
- `active_layer`  out  LAYER_W  tag of active buffer
- `active_ready`  out  1  active buffer holds a complete load
- `busy`  out  1  load in progress

## Operation
- Storage is two buffers selected by `active_sel`. The shadow buffer is `!active_sel`. Use inferred block RAM. Memory contents are not reset.
- Load FSM states: IDLE, LOAD, FULL.
  - IDLE/FULL to LOAD on `load_start & csen`. Capture the tag and length, and clear the write pointer and the shadow valid flag.
  - If `load_len == 0`: go directly to FULL and pulse `load_done` next cycle.
  - LOAD: each `wr_valid & wr_ready` beat writes `wr_data` at the shadow pointer, then increments the pointer.
  - When the beat at pointer `len-1` is accepted, go to FULL, set shadow valid, and pulse `load_done` the following cycle.
  - `load_start` during LOAD aborts and restarts: the pointer is cleared and the new tag and length are captured.
- `wr_ready = csen & (state == LOAD)`. Beats beyond `len` are never accepted.
- Swap accepted only when `csen & state == FULL`. The FSM then returns to IDLE.
  - On accept: toggle `active_sel`; the active tag, length and valid take the shadow values; the old active buffer becomes shadow (invalid).
  - `swap` in IDLE or LOAD is ignored and pulses `swap_err`.
- `swap` and `load_start` in the same cycle while in FULL: both are accepted. The swap executes, and the load begins into the new shadow buffer (the old active buffer).
- Read path:
  - When `rd_en & csen & active_ready & rd_addr < active_len`: `rd_data` takes the active word and `rd_valid` = 1.
  - When `rd_en & csen` with the address out of range or no ready buffer: `rd_data` = 0, `rd_valid` = 0, `rd_oob` = 1.
  - Otherwise `rd_data` = 0 and all flags are 0.
- Reads and loads proceed concurrently without interference, because they target different buffers.
- Reset mid-operation: FSM to IDLE; `active_sel` = 0; both valid flags cleared; tags and lengths = 0; all in-flight data is discarded.

## Timing
- Reset values: `rd_data` 0, `rd_valid` 0, `rd_oob` 0, `load_done` 0, `swap_err` 0, `active_layer` 0, `active_ready` 0, `busy` 0. `wr_ready` is 0 because the FSM is IDLE.
- Read latency is 1 cycle. `rd_data`, `rd_valid` and `rd_oob` are registered, and a request at edge N is visible after edge N+1.
- Swap takes effect at the next edge. A read issued in the cycle after the swap is accepted returns new-buffer data.
- A read issued in the same cycle as `swap` returns old-buffer data.
- `load_done` rises the cycle after the last beat. `busy` is high exactly while the FSM is in LOAD.
- Sustained throughput is one load beat per cycle and one read per cycle.

## Configuration
- `WEIGHT_PARITY_EN` defined:
  - Each stored word carries an extra even-parity bit computed on write.
  - Added output `rd_perr` (1 bit, reset 0) is registered with `rd_data` and is high when a valid read's recomputed parity mismatches the stored bit.
  - Storage width becomes DATA_WIDTH+1.
- `WEIGHT_PARITY_EN` undefined:
  - No parity storage.
  - The `rd_perr` port is absent.

## Test plan
- Load tag 3, length 4, data 0x11,0x22,0x33,0x44 with `wr_valid` held high -> `wr_ready` high for 4 cycles, `load_done` pulses 1 cycle after the 4th beat; then swap -> `active_layer` = 3, `active_ready` = 1; read addr 2 -> `rd_data` = 0x33 one cycle later.
- With buffer A active (tag 1), stream tag 2 into B while reading A at addr 0..3 every cycle -> all reads return A data; after swap, read addr 0 returns B's first word.
- Read addr 4 with active length 4 -> `rd_data` = 0, `rd_valid` = 0, `rd_oob` = 1; `swap` in IDLE -> `swap_err` pulse, `active_layer` unchanged.
- `load_start` in FULL together with `swap` -> swap applied, `busy` = 1 next cycle, and new beats land in the old active buffer (verified after a second swap).
- Deassert `rst_n` in the middle of a 10-word load -> all outputs 0 immediately, `wr_ready` = 0; `swap` after reset -> `swap_err`.
- `load_len` = 0 -> `load_done` pulse with no beats accepted. Under `WEIGHT_PARITY_EN`, force-flip a stored bit -> `rd_perr` = 1 on that read.
